// File: rtl/s526a_bist_ctrl.sv
// BIST sequencer for the s526a core: clears it via G0, drives LFSR stimulus on G1/G2 and
// compacts the six core outputs into a 16-bit MISR. Optional PASS compare: BIST_SIG_CHECK_EN.
module s526a_bist_ctrl #(
  parameter int unsigned NCYC      = 256,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned INIT_CYC  = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [15:0] EXP_SIG   = 16'h0000
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             START,
  output logic             BUSY,
  output logic             DONE,
  output logic             DUT_G0,
  output logic             DUT_G1,
  output logic             DUT_G2,
  input  logic [5:0]       DUT_OUT,
  output logic [15:0]      SIG,
  output logic [CNT_W-1:0] CYC
`ifdef BIST_SIG_CHECK_EN
  ,
  output logic             PASS
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LP_NCYC  = CNT_W'(NCYC);
  localparam logic [3:0]       LP_ILAST = 4'(INIT_CYC - 1);

  // Shared feedback polynomial x^16+x^14+x^13+x^11+1 for both LFSR and MISR.
  function automatic logic [15:0] shift16(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  state_t           r_state;
  logic [3:0]       r_icnt;
  logic [15:0]      r_lfsr;
  logic [15:0]      r_sig;
  logic [CNT_W-1:0] r_cyc;
  logic             r_busy, r_done, r_g0, r_g1, r_g2, r_pass;

  logic [15:0]      w_lfsr_nxt;
  logic [15:0]      w_sig_nxt;
  logic [CNT_W-1:0] w_cyc_nxt;

  assign w_lfsr_nxt = shift16(r_lfsr);
  assign w_sig_nxt  = shift16(r_sig) ^ {10'b0, DUT_OUT};
  assign w_cyc_nxt  = r_cyc + 1'b1;

  always_ff @(posedge CK) begin
    if (!RN) begin
      r_state <= S_IDLE;
      r_icnt  <= '0;
      r_lfsr  <= LFSR_SEED;
      r_sig   <= '0;
      r_cyc   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_g0    <= 1'b0;
      r_g1    <= 1'b0;
      r_g2    <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (START) begin
            r_state <= S_INIT;
            r_icnt  <= '0;
            r_lfsr  <= LFSR_SEED;
            r_sig   <= '0;
            r_cyc   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_g0    <= 1'b1;
            r_g1    <= 1'b0;
            r_g2    <= 1'b0;
            r_pass  <= 1'b0;
          end
        end
        S_INIT: begin
          if (r_icnt == LP_ILAST) begin
            // LFSR still holds the seed, so the first RUN cycle shows seed bits.
            r_state <= S_RUN;
            r_g0    <= 1'b0;
            r_g1    <= r_lfsr[1];
            r_g2    <= r_lfsr[2];
          end else begin
            r_icnt <= r_icnt + 1'b1;
          end
        end
        S_RUN: begin
          r_lfsr <= w_lfsr_nxt;
          r_sig  <= w_sig_nxt;
          r_cyc  <= w_cyc_nxt;
          if (w_cyc_nxt == LP_NCYC) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_g1    <= 1'b0;
            r_g2    <= 1'b0;
            r_pass  <= (w_sig_nxt == EXP_SIG);
          end else begin
            r_g1 <= w_lfsr_nxt[1];
            r_g2 <= w_lfsr_nxt[2];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign BUSY   = r_busy;
  assign DONE   = r_done;
  assign DUT_G0 = r_g0;
  assign DUT_G1 = r_g1;
  assign DUT_G2 = r_g2;
  assign SIG    = r_sig;
  assign CYC    = r_cyc;

`ifdef BIST_SIG_CHECK_EN
  assign PASS = r_pass;
`else
  logic w_unused_pass;
  assign w_unused_pass = r_pass ^ (^EXP_SIG);
`endif

endmodule

// File: tb/tb_s526a_bist_ctrl.sv
// Self-checking bench for s526a_bist_ctrl: randomized core responses checked against a
// sequence-level model of the LFSR stimulus and MISR signature.
module tb_s526a_bist_ctrl;

  logic        ck = 1'b0;
  logic        rn = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [5:0]  dout_a = '0, dout_b = '0, dout_c = '0;
  logic        busy_a, done_a, g0_a, g1_a, g2_a;
  logic        busy_b, done_b, g0_b, g1_b, g2_b;
  logic        busy_c, done_c, g0_c, g1_c, g2_c;
  logic [15:0] sig_a, sig_b, sig_c;
  logic [15:0] cyc_a, cyc_b, cyc_c;
`ifdef BIST_SIG_CHECK_EN
  logic        pass_a, pass_b, pass_c;
`endif

  int          n_chk = 0;
  int          n_fail = 0;
  logic [5:0]  rec [0:7];
  logic [15:0] first_sig;

  always #5 ck = ~ck;

  s526a_bist_ctrl #(.NCYC(8), .CNT_W(16), .INIT_CYC(4), .LFSR_SEED(16'hACE1),
                    .EXP_SIG(16'h0000)) u_a (
    .CK(ck), .RN(rn), .START(start_a), .BUSY(busy_a), .DONE(done_a),
    .DUT_G0(g0_a), .DUT_G1(g1_a), .DUT_G2(g2_a), .DUT_OUT(dout_a),
    .SIG(sig_a), .CYC(cyc_a)
`ifdef BIST_SIG_CHECK_EN
    , .PASS(pass_a)
`endif
  );

  s526a_bist_ctrl #(.NCYC(2), .CNT_W(16), .INIT_CYC(4), .LFSR_SEED(16'hACE1),
                    .EXP_SIG(16'h0003)) u_b (
    .CK(ck), .RN(rn), .START(start_b), .BUSY(busy_b), .DONE(done_b),
    .DUT_G0(g0_b), .DUT_G1(g1_b), .DUT_G2(g2_b), .DUT_OUT(dout_b),
    .SIG(sig_b), .CYC(cyc_b)
`ifdef BIST_SIG_CHECK_EN
    , .PASS(pass_b)
`endif
  );

  s526a_bist_ctrl #(.NCYC(1), .CNT_W(16), .INIT_CYC(4), .LFSR_SEED(16'hACE1),
                    .EXP_SIG(16'h0004)) u_c (
    .CK(ck), .RN(rn), .START(start_c), .BUSY(busy_c), .DONE(done_c),
    .DUT_G0(g0_c), .DUT_G1(g1_c), .DUT_G2(g2_c), .DUT_OUT(dout_c),
    .SIG(sig_c), .CYC(cyc_c)
`ifdef BIST_SIG_CHECK_EN
    , .PASS(pass_c)
`endif
  );

  // Reference shift: x<<1 with feedback x15^x13^x12^x10 in the low bit.
  function automatic logic [15:0] ref_step(input logic [15:0] x);
    int unsigned v, f;
    v = 32'(x);
    f = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return 16'((v << 1) | f);
  endfunction

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic test_reset();
    rn = 1'b0;
    start_a = 1'b1; start_b = 1'b1; start_c = 1'b1;
    tick(); tick();
    n_chk++;
    if ({busy_a, done_a, g0_a, g1_a, g2_a, sig_a, cyc_a} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_a: got busy/done/g=%b%b%b%b%b sig=%h cyc=%0d, want all 0",
               busy_a, done_a, g0_a, g1_a, g2_a, sig_a, cyc_a);
    end
    n_chk++;
    if ({busy_b, done_b, g0_b, g1_b, g2_b, sig_b, cyc_b,
         busy_c, done_c, g0_c, g1_c, g2_c, sig_c, cyc_c} !== 74'd0) begin
      n_fail++;
      $display("FAIL reset_bc: got b=%b%b%b%b%b/%h/%0d c=%b%b%b%b%b/%h/%0d, want all 0",
               busy_b, done_b, g0_b, g1_b, g2_b, sig_b, cyc_b,
               busy_c, done_c, g0_c, g1_c, g2_c, sig_c, cyc_c);
    end
`ifdef BIST_SIG_CHECK_EN
    n_chk++;
    if ({pass_a, pass_b, pass_c} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_pass: got %b%b%b, want 000", pass_a, pass_b, pass_c);
    end
`endif
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    rn = 1'b1;
    tick();
    n_chk++;
    if ({busy_a, done_a} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_release_idle: got busy=%b done=%b, want 0 0", busy_a, done_a);
    end
  endtask

  // Full NCYC=8 run on u_a; inject puts START pulses into INIT and RUN, reuse replays rec[].
  task automatic test_sequence(input bit inject, input bit reuse, output logic [15:0] sig_out);
    logic [15:0] l_model, s_model;
    logic [5:0]  d;
    l_model = 16'hACE1;
    s_model = 16'h0000;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n_chk++;
    if (sig_a !== 16'h0000 || cyc_a !== 16'd0) begin
      n_fail++;
      $display("FAIL start_clear: got sig=%h cyc=%0d, want 0000 0", sig_a, cyc_a);
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({busy_a, done_a, g0_a, g1_a, g2_a} !== 5'b10100) begin
        n_fail++;
        $display("FAIL init_cycle%0d: got busy/done/g0/g1/g2=%b%b%b%b%b, want 10100",
                 i, busy_a, done_a, g0_a, g1_a, g2_a);
      end
      start_a = inject && (i == 1);
      tick();
    end
    start_a = 1'b0;
    for (int j = 0; j < 8; j++) begin
      n_chk++;
      if ({busy_a, done_a, g0_a, g1_a, g2_a} !== {3'b100, l_model[1], l_model[2]}) begin
        n_fail++;
        $display("FAIL run_cycle%0d_outputs: got busy/done/g0/g1/g2=%b%b%b%b%b, want 100%b%b",
                 j, busy_a, done_a, g0_a, g1_a, g2_a, l_model[1], l_model[2]);
      end
      n_chk++;
      if (cyc_a !== 16'(j)) begin
        n_fail++;
        $display("FAIL run_cycle%0d_cyc: got %0d, want %0d", j, cyc_a, j);
      end
      if (j == 1) begin
        n_chk++;
        if ({g1_a, g2_a} !== 2'b10) begin
          n_fail++;
          $display("FAIL second_run_g1g2: got %b%b, want 10", g1_a, g2_a);
        end
      end
      d = reuse ? rec[j] : 6'($urandom);
      rec[j] = d;
      dout_a = d;
      start_a = inject && (j == 2 || j == 7);
      tick();
      s_model = ref_step(s_model) ^ {10'b0, d};
      l_model = ref_step(l_model);
    end
    start_a = 1'b0;
    n_chk++;
    if ({busy_a, done_a, g0_a, g1_a, g2_a} !== 5'b01000 || cyc_a !== 16'd8) begin
      n_fail++;
      $display("FAIL done_edge: got busy/done/g=%b%b%b%b%b cyc=%0d, want 01000 8",
               busy_a, done_a, g0_a, g1_a, g2_a, cyc_a);
    end
    n_chk++;
    if (sig_a !== s_model) begin
      n_fail++;
      $display("FAIL signature: got %h, want %h", sig_a, s_model);
    end
    dout_a = 6'($urandom);
    tick(); tick();
    n_chk++;
    if (done_a !== 1'b1 || sig_a !== s_model || cyc_a !== 16'd8) begin
      n_fail++;
      $display("FAIL done_hold: got done=%b sig=%h cyc=%0d, want 1 %h 8",
               done_a, sig_a, cyc_a, s_model);
    end
    sig_out = s_model;
  endtask

  task automatic test_busy_rerun();
    logic [15:0] s2;
    test_sequence(1'b1, 1'b1, s2);
    n_chk++;
    if (sig_a !== first_sig) begin
      n_fail++;
      $display("FAIL rerun_same_sig: got %h, want %h", sig_a, first_sig);
    end
  endtask

  task automatic test_abort();
    logic [15:0] s3;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (7) tick();
    n_chk++;
    if (cyc_a !== 16'd3 || busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre: got cyc=%0d busy=%b, want 3 1", cyc_a, busy_a);
    end
    rn = 1'b0;
    tick();
    n_chk++;
    if ({busy_a, done_a, g0_a, g1_a, g2_a, sig_a, cyc_a} !== 37'd0) begin
      n_fail++;
      $display("FAIL abort_state: got busy/done/g=%b%b%b%b%b sig=%h cyc=%0d, want all 0",
               busy_a, done_a, g0_a, g1_a, g2_a, sig_a, cyc_a);
    end
    rn = 1'b1;
    tick();
    test_sequence(1'b0, 1'b0, s3);
  endtask

  task automatic test_misr();
    int n;
    // NCYC=2, DUT_OUT=1
    dout_b = 6'h01;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    n = 0;
    while (done_b !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    n_chk++;
    if (n != 6) begin
      n_fail++;
      $display("FAIL misr_b_done_edge: got edge %0d, want 6", n);
    end
    n_chk++;
    if (sig_b !== 16'h0003 || cyc_b !== 16'd2) begin
      n_fail++;
      $display("FAIL misr_ncyc2_one: got sig=%h cyc=%0d, want 0003 2", sig_b, cyc_b);
    end
`ifdef BIST_SIG_CHECK_EN
    n_chk++;
    if (pass_b !== 1'b1) begin
      n_fail++;
      $display("FAIL pass_match: got %b, want 1", pass_b);
    end
`endif
    // NCYC=1, DUT_OUT=1
    dout_c = 6'h01;
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    n = 0;
    while (done_c !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    n_chk++;
    if (n != 5 || sig_c !== 16'h0001 || cyc_c !== 16'd1) begin
      n_fail++;
      $display("FAIL misr_ncyc1_one: got edge=%0d sig=%h cyc=%0d, want 5 0001 1", n, sig_c, cyc_c);
    end
`ifdef BIST_SIG_CHECK_EN
    n_chk++;
    if (pass_c !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_mismatch_c: got %b, want 0", pass_c);
    end
`endif
    // NCYC=2, DUT_OUT=0, restarted straight from DONE
    dout_b = 6'h00;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    n_chk++;
    if ({busy_b, done_b, sig_b} !== {2'b10, 16'h0000}) begin
      n_fail++;
      $display("FAIL restart_from_done: got busy=%b done=%b sig=%h, want 1 0 0000",
               busy_b, done_b, sig_b);
    end
    n = 0;
    while (done_b !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    n_chk++;
    if (n != 6 || sig_b !== 16'h0000) begin
      n_fail++;
      $display("FAIL misr_zero: got edge=%0d sig=%h, want 6 0000", n, sig_b);
    end
`ifdef BIST_SIG_CHECK_EN
    n_chk++;
    if (pass_b !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_mismatch_b: got %b, want 0", pass_b);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_sequence(1'b0, 1'b0, first_sig);
    test_busy_rerun();
    test_abort();
    test_misr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
